// File: rtl/stack_cmd_seq_if.sv
// stack_cmd_seq_if: command/response bundle for the stack sequencer.
// master issues commands and collects responses; slave is the sequencer.
interface stack_cmd_seq_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic       cmd_sel;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic [1:0] rsp_err;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_sel,
    output cmd_data,
    input  cmd_ready,
    input  rsp_valid,
    input  rsp_data,
    input  rsp_err
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_sel,
    input  cmd_data,
    output cmd_ready,
    output rsp_valid,
    output rsp_data,
    output rsp_err
  );
endinterface

// File: rtl/stack_cmd_seq.sv
// stack_cmd_seq: sequences one command at a time onto the shared
// two-stack strobe bus and returns a single response pulse.
module stack_cmd_seq #(
  parameter bit SATURATE = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  stack_cmd_seq_if.slave cmd,
  output logic          stack_select,
  output logic          push,
  output logic          pop,
  output logic [7:0]    data_in,
  input  logic          empty0,
  input  logic          empty1,
  input  logic          full0,
  input  logic          full1,
  input  logic [7:0]    dout0,
  input  logic [7:0]    dout1
);

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_PUSH = 3'd1;
  localparam logic [2:0] OP_POP  = 3'd2;
  localparam logic [2:0] OP_PEEK = 3'd3;
  localparam logic [2:0] OP_DUP  = 3'd4;
  localparam logic [2:0] OP_SWAP = 3'd5;
  localparam logic [2:0] OP_ADD  = 3'd6;
  localparam logic [2:0] OP_MOVE = 3'd7;

  localparam logic [1:0] E_OK    = 2'b00;
  localparam logic [1:0] E_UNDER = 2'b01;
  localparam logic [1:0] E_OVER  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_EXEC,
    S_EXEC2,
    S_EXEC3,
    S_XFER,
    S_DONE
  } state_t;

  state_t     state;
  logic [2:0] op_q;
  logic       sel_q;
  logic [7:0] data_q;
  logic [7:0] t0;
  logic [7:0] t1;

  logic [7:0] op_oh;
  logic [7:0] top;
  logic       emp;
  logic       ful;
  logic       ful_dst;
  logic [8:0] sum_raw;
  logic [7:0] sum;

  assign op_oh   = 8'd1 << op_q;
  assign top     = sel_q ? dout1 : dout0;
  assign emp     = sel_q ? empty1 : empty0;
  assign ful     = sel_q ? full1 : full0;
  assign ful_dst = sel_q ? full0 : full1;
  assign sum_raw = {1'b0, t0} + {1'b0, top};
  assign sum     = (SATURATE && sum_raw[8]) ? 8'hFF : sum_raw[7:0];

  assign cmd.cmd_ready = (state == S_IDLE);

  // MOVE retargets the bus to the destination for its one push cycle
  assign stack_select = (state == S_XFER) ? ~sel_q : sel_q;

  // Strobe decode: only the working states ever touch the stacks
  always_comb begin
    push    = 1'b0;
    pop     = 1'b0;
    data_in = 8'h00;
    unique case (state)
      S_EXEC: begin
        unique case (1'b1)
          op_oh[OP_PUSH]: begin
            if (!ful) begin
              push    = 1'b1;
              data_in = data_q;
            end
          end
          op_oh[OP_POP]: begin
            if (!emp) pop = 1'b1;
          end
          op_oh[OP_DUP]: begin
            if (!emp && !ful) begin
              push    = 1'b1;
              data_in = top;
            end
          end
          op_oh[OP_SWAP],
          op_oh[OP_ADD]: begin
            if (!emp) pop = 1'b1;
          end
          op_oh[OP_MOVE]: begin
            if (!emp && !ful_dst) pop = 1'b1;
          end
          default: ;
        endcase
      end
      S_EXEC2: begin
        if (emp) begin
          push    = 1'b1;
          data_in = t0;
        end else begin
          push    = 1'b1;
          pop     = 1'b1;
          data_in = (op_q == OP_ADD) ? sum : t0;
        end
      end
      S_EXEC3: begin
        push    = 1'b1;
        data_in = t1;
      end
      S_XFER: begin
        push    = 1'b1;
        data_in = t0;
      end
      default: ;
    endcase
  end

  // Command FSM; response fields load only on entry to DONE
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      op_q          <= OP_NOP;
      sel_q         <= 1'b0;
      data_q        <= 8'h00;
      t0            <= 8'h00;
      t1            <= 8'h00;
      cmd.rsp_valid <= 1'b0;
      cmd.rsp_data  <= 8'h00;
      cmd.rsp_err   <= E_OK;
    end else begin
      cmd.rsp_valid <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (cmd.cmd_valid) begin
            op_q   <= cmd.cmd_op;
            sel_q  <= cmd.cmd_sel;
            data_q <= cmd.cmd_data;
            state  <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          state <= S_EXEC;
        end
        S_EXEC: begin
          unique case (1'b1)
            op_oh[OP_NOP]: begin
              state         <= S_DONE;
              cmd.rsp_valid <= 1'b1;
              cmd.rsp_data  <= 8'h00;
              cmd.rsp_err   <= E_OK;
            end
            op_oh[OP_PUSH]: begin
              state         <= S_DONE;
              cmd.rsp_valid <= 1'b1;
              cmd.rsp_data  <= ful ? 8'h00 : data_q;
              cmd.rsp_err   <= ful ? E_OVER : E_OK;
            end
            op_oh[OP_POP],
            op_oh[OP_PEEK]: begin
              state         <= S_DONE;
              cmd.rsp_valid <= 1'b1;
              cmd.rsp_data  <= emp ? 8'h00 : top;
              cmd.rsp_err   <= emp ? E_UNDER : E_OK;
              if (!emp) t0 <= top;
            end
            op_oh[OP_DUP]: begin
              state         <= S_DONE;
              cmd.rsp_valid <= 1'b1;
              if (emp) begin
                cmd.rsp_data <= 8'h00;
                cmd.rsp_err  <= E_UNDER;
              end else if (ful) begin
                cmd.rsp_data <= 8'h00;
                cmd.rsp_err  <= E_OVER;
              end else begin
                cmd.rsp_data <= top;
                cmd.rsp_err  <= E_OK;
              end
            end
            op_oh[OP_SWAP],
            op_oh[OP_ADD]: begin
              if (emp) begin
                state         <= S_DONE;
                cmd.rsp_valid <= 1'b1;
                cmd.rsp_data  <= 8'h00;
                cmd.rsp_err   <= E_UNDER;
              end else begin
                t0    <= top;
                state <= S_EXEC2;
              end
            end
            op_oh[OP_MOVE]: begin
              if (emp || ful_dst) begin
                state         <= S_DONE;
                cmd.rsp_valid <= 1'b1;
                cmd.rsp_data  <= 8'h00;
                cmd.rsp_err   <= emp ? E_UNDER : E_OVER;
              end else begin
                t0    <= top;
                state <= S_XFER;
              end
            end
            default: state <= S_DONE;
          endcase
        end
        S_EXEC2: begin
          if (emp) begin
            state         <= S_DONE;
            cmd.rsp_valid <= 1'b1;
            cmd.rsp_data  <= 8'h00;
            cmd.rsp_err   <= E_UNDER;
          end else if (op_q == OP_ADD) begin
            state         <= S_DONE;
            cmd.rsp_valid <= 1'b1;
            cmd.rsp_data  <= sum;
            cmd.rsp_err   <= E_OK;
          end else begin
            t1    <= top;
            state <= S_EXEC3;
          end
        end
        S_EXEC3: begin
          state         <= S_DONE;
          cmd.rsp_valid <= 1'b1;
          cmd.rsp_data  <= t1;
          cmd.rsp_err   <= E_OK;
        end
        S_XFER: begin
          state         <= S_DONE;
          cmd.rsp_valid <= 1'b1;
          cmd.rsp_data  <= t0;
          cmd.rsp_err   <= E_OK;
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stack_cmd_seq.sv
// tb_stack_cmd_seq: directed vectors for the stack command sequencer,
// two DUTs (wrap / saturate) each driving its own pair of model stacks.
module tb_stack_cmd_seq;

  localparam int WORDS = 4;

  localparam logic [2:0] NOP  = 3'd0;
  localparam logic [2:0] PUSH = 3'd1;
  localparam logic [2:0] POP  = 3'd2;
  localparam logic [2:0] PEEK = 3'd3;
  localparam logic [2:0] DUP  = 3'd4;
  localparam logic [2:0] SWAP = 3'd5;
  localparam logic [2:0] ADD  = 3'd6;
  localparam logic [2:0] MOVE = 3'd7;

  logic clk;
  logic rst_n;

  stack_cmd_seq_if c0 ();
  stack_cmd_seq_if c1 ();

  logic [1:0] ssel;
  logic [1:0] push_s;
  logic [1:0] pop_s;
  logic [7:0] din_s  [2];
  logic       emp_s  [2][2];
  logic       full_s [2][2];
  logic [7:0] dout_s [2][2];

  logic [7:0] mem  [2][2][WORDS];
  int         cnt  [2][2];
  logic       selq [2][2];

  int n_cmp;
  int n_bad;

  stack_cmd_seq #(.SATURATE(1'b0)) u_wrap (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd          (c0),
    .stack_select (ssel[0]),
    .push         (push_s[0]),
    .pop          (pop_s[0]),
    .data_in      (din_s[0]),
    .empty0       (emp_s[0][0]),
    .empty1       (emp_s[0][1]),
    .full0        (full_s[0][0]),
    .full1        (full_s[0][1]),
    .dout0        (dout_s[0][0]),
    .dout1        (dout_s[0][1])
  );

  stack_cmd_seq #(.SATURATE(1'b1)) u_sat (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd          (c1),
    .stack_select (ssel[1]),
    .push         (push_s[1]),
    .pop          (pop_s[1]),
    .data_in      (din_s[1]),
    .empty0       (emp_s[1][0]),
    .empty1       (emp_s[1][1]),
    .full0        (full_s[1][0]),
    .full1        (full_s[1][1]),
    .dout0        (dout_s[1][0]),
    .dout1        (dout_s[1][1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Model stacks: gated on their address, registered select
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      for (int a = 0; a < 2; a++) begin
        if (!rst_n) begin
          cnt[i][a]  <= 0;
          selq[i][a] <= 1'b0;
        end else begin
          selq[i][a] <= (ssel[i] == a[0]);
          if (ssel[i] == a[0]) begin
            if (push_s[i] && pop_s[i]) begin
              if (cnt[i][a] > 0) mem[i][a][cnt[i][a]-1] <= din_s[i];
            end else if (push_s[i]) begin
              if (cnt[i][a] < WORDS) begin
                mem[i][a][cnt[i][a]] <= din_s[i];
                cnt[i][a] <= cnt[i][a] + 1;
              end
            end else if (pop_s[i]) begin
              if (cnt[i][a] > 0) cnt[i][a] <= cnt[i][a] - 1;
            end
          end
        end
      end
    end
  end

  // Model stack status and read port
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      for (int a = 0; a < 2; a++) begin
        emp_s[i][a]  = 1'b0;
        full_s[i][a] = 1'b0;
        dout_s[i][a] = 8'h00;
        emp_s[i][a]  = (cnt[i][a] == 0);
        full_s[i][a] = (cnt[i][a] == WORDS);
        if (selq[i][a] && cnt[i][a] > 0)
          dout_s[i][a] = mem[i][a][cnt[i][a]-1];
      end
    end
  end

  // Bus legality on every strobe
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        if (push_s[i] && !pop_s[i])
          chk("push_when_full", full_s[i][ssel[i]], 1'b0);
        if (pop_s[i])
          chk("pop_when_empty", emp_s[i][ssel[i]], 1'b0);
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic sel,
                       input logic [7:0] d);
    c0.cmd_valid = 1'b1;
    c0.cmd_op    = op;
    c0.cmd_sel   = sel;
    c0.cmd_data  = d;
    c1.cmd_valid = 1'b1;
    c1.cmd_op    = op;
    c1.cmd_sel   = sel;
    c1.cmd_data  = d;
  endtask

  task automatic idle_bus();
    c0.cmd_valid = 1'b0;
    c1.cmd_valid = 1'b0;
  endtask

  task automatic run(input string tag, input logic [2:0] op,
                     input logic sel, input logic [7:0] d,
                     input int lat, input logic [7:0] ed0,
                     input logic [7:0] ed1, input logic [1:0] ee);
    int  k;
    bit  seen;
    @(negedge clk);
    chk({tag, ".ready"}, c0.cmd_ready, 1'b1);
    issue(op, sel, d);
    @(negedge clk);
    idle_bus();
    k    = 1;
    seen = 1'b0;
    while (!seen && k <= 8) begin
      if (c0.rsp_valid) seen = 1'b1;
      else begin
        @(negedge clk);
        k++;
      end
    end
    chk({tag, ".lat"}, k, lat);
    chk({tag, ".data"}, c0.rsp_data, ed0);
    chk({tag, ".err"}, c0.rsp_err, ee);
    chk({tag, ".sat_valid"}, c1.rsp_valid, 1'b1);
    chk({tag, ".sat_data"}, c1.rsp_data, ed1);
    @(negedge clk);
    chk({tag, ".pulse"}, c0.rsp_valid, 1'b0);
    chk({tag, ".hold"}, c0.rsp_data, ed0);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    idle_bus();
    issue(NOP, 1'b0, 8'h00);
    idle_bus();
    repeat (3) @(negedge clk);

    chk("rst.ready", c0.cmd_ready, 1'b1);
    chk("rst.valid", c0.rsp_valid, 1'b0);
    chk("rst.data", c0.rsp_data, 8'h00);
    chk("rst.err", c0.rsp_err, 2'b00);
    chk("rst.sel", ssel[0], 1'b0);
    chk("rst.push", push_s[0], 1'b0);
    chk("rst.pop", pop_s[0], 1'b0);
    chk("rst.din", din_s[0], 8'h00);
    rst_n = 1'b1;

    run("nop", NOP, 1'b0, 8'h5A, 3, 8'h00, 8'h00, 2'b00);
    run("push11", PUSH, 1'b0, 8'h11, 3, 8'h11, 8'h11, 2'b00);
    run("push22", PUSH, 1'b0, 8'h22, 3, 8'h22, 8'h22, 2'b00);
    run("pop22", POP, 1'b0, 8'h00, 3, 8'h22, 8'h22, 2'b00);
    run("pop11", POP, 1'b0, 8'h00, 3, 8'h11, 8'h11, 2'b00);
    run("pop_under", POP, 1'b0, 8'h00, 3, 8'h00, 8'h00, 2'b01);
    chk("t1.depth0", cnt[0][0], 0);
    run("peek_under", PEEK, 1'b0, 8'h00, 3, 8'h00, 8'h00, 2'b01);
    run("dup_under", DUP, 1'b0, 8'h00, 3, 8'h00, 8'h00, 2'b01);

    run("push05", PUSH, 1'b0, 8'h05, 3, 8'h05, 8'h05, 2'b00);
    run("push07", PUSH, 1'b0, 8'h07, 3, 8'h07, 8'h07, 2'b00);
    run("swap", SWAP, 1'b0, 8'h00, 5, 8'h05, 8'h05, 2'b00);
    chk("swap.depth", cnt[0][0], 2);
    run("swap.pop1", POP, 1'b0, 8'h00, 3, 8'h05, 8'h05, 2'b00);
    run("swap.pop2", POP, 1'b0, 8'h00, 3, 8'h07, 8'h07, 2'b00);
    run("push99", PUSH, 1'b0, 8'h99, 3, 8'h99, 8'h99, 2'b00);
    run("swap1", SWAP, 1'b0, 8'h00, 4, 8'h00, 8'h00, 2'b01);
    chk("swap1.depth", cnt[0][0], 1);
    run("swap1.pop", POP, 1'b0, 8'h00, 3, 8'h99, 8'h99, 2'b00);

    run("pushF0", PUSH, 1'b0, 8'hF0, 3, 8'hF0, 8'hF0, 2'b00);
    run("push20", PUSH, 1'b0, 8'h20, 3, 8'h20, 8'h20, 2'b00);
    run("add", ADD, 1'b0, 8'h00, 4, 8'h10, 8'hFF, 2'b00);
    chk("add.depth", cnt[0][0], 1);
    chk("add.sat_depth", cnt[1][0], 1);
    run("add.pop", POP, 1'b0, 8'h00, 3, 8'h10, 8'hFF, 2'b00);
    run("push33", PUSH, 1'b0, 8'h33, 3, 8'h33, 8'h33, 2'b00);
    run("add1", ADD, 1'b0, 8'h00, 4, 8'h00, 8'h00, 2'b01);
    run("add1.pop", POP, 1'b0, 8'h00, 3, 8'h33, 8'h33, 2'b00);

    run("push5A", PUSH, 1'b0, 8'h5A, 3, 8'h5A, 8'h5A, 2'b00);
    run("dup", DUP, 1'b0, 8'h00, 3, 8'h5A, 8'h5A, 2'b00);
    chk("dup.depth", cnt[0][0], 2);
    run("dup.pop1", POP, 1'b0, 8'h00, 3, 8'h5A, 8'h5A, 2'b00);
    run("dup.pop2", POP, 1'b0, 8'h00, 3, 8'h5A, 8'h5A, 2'b00);

    run("push01", PUSH, 1'b0, 8'h01, 3, 8'h01, 8'h01, 2'b00);
    run("push3C", PUSH, 1'b0, 8'h3C, 3, 8'h3C, 8'h3C, 2'b00);
    run("move", MOVE, 1'b0, 8'h00, 4, 8'h3C, 8'h3C, 2'b00);
    chk("move.src_depth", cnt[0][0], 1);
    chk("move.dst_depth", cnt[0][1], 1);
    run("move.peek", PEEK, 1'b1, 8'h00, 3, 8'h3C, 8'h3C, 2'b00);

    run("push42", PUSH, 1'b1, 8'h42, 3, 8'h42, 8'h42, 2'b00);
    run("push43", PUSH, 1'b1, 8'h43, 3, 8'h43, 8'h43, 2'b00);
    run("push44", PUSH, 1'b1, 8'h44, 3, 8'h44, 8'h44, 2'b00);
    run("push_over", PUSH, 1'b1, 8'hAA, 3, 8'h00, 8'h00, 2'b10);
    chk("over.depth", cnt[0][1], WORDS);
    run("over.peek", PEEK, 1'b1, 8'h00, 3, 8'h44, 8'h44, 2'b00);
    run("dup_over", DUP, 1'b1, 8'h00, 3, 8'h00, 8'h00, 2'b10);
    run("src.peek", PEEK, 1'b0, 8'h00, 3, 8'h01, 8'h01, 2'b00);
    run("move_over", MOVE, 1'b0, 8'h00, 3, 8'h00, 8'h00, 2'b10);
    chk("move_over.src", cnt[0][0], 1);
    chk("move_over.dst", cnt[0][1], WORDS);

    @(negedge clk);
    issue(SWAP, 1'b1, 8'h00);
    @(negedge clk);
    idle_bus();
    @(negedge clk);
    @(negedge clk);
    chk("mid.pre_sel", ssel[0], 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid.valid", c0.rsp_valid, 1'b0);
    chk("mid.ready", c0.cmd_ready, 1'b1);
    chk("mid.err", c0.rsp_err, 2'b00);
    chk("mid.data", c0.rsp_data, 8'h00);
    chk("mid.sel", ssel[0], 1'b0);
    chk("mid.push", push_s[0], 1'b0);
    chk("mid.pop", pop_s[0], 1'b0);
    chk("mid.din", din_s[0], 8'h00);
    chk("mid.depth0", cnt[0][0], 0);
    chk("mid.depth1", cnt[0][1], 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid.no_rsp", c0.rsp_valid, 1'b0);
    run("post.peek", PEEK, 1'b1, 8'h00, 3, 8'h00, 8'h00, 2'b01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
